// File: rtl/dfx_led_mux.sv
// dfx_led_mux: glitch-free RP LED source select with blanking, decouple handshake and blinker fallback.
// Define DFX_LED_MUX_STALE_EN to build the per-source toggle watchdogs (stale_o, stale fallback).
module dfx_led_mux #(
  parameter int   NUM_SRC   = 3,
  parameter int   SEL_W     = 2,
  parameter int   BLANK_CYC = 16,
  parameter int   STALE_CYC = 100000000,
  parameter int   FB_DIV    = 24,
  parameter logic SAFE_VAL  = 1'b0
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               decouple_i,
  output logic               led_o,
  output logic               decoupled_o,
  output logic [SEL_W-1:0]   active_sel_o,
  output logic [NUM_SRC-1:0] stale_o,
  output logic               fallback_o
);

  localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC - 1);

  if ((NUM_SRC < 2) || (NUM_SRC > 16) || ((1 << SEL_W) < NUM_SRC) ||
      (BLANK_CYC < 1) || (STALE_CYC < 1) || (FB_DIV < 0)) begin : g_bad_params
    $error("dfx_led_mux: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BLANK     = 2'd1,
    ST_DECOUPLED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     pend_sel_q, pend_sel_d;
  logic [SEL_W-1:0]     active_sel_d;
  logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
  logic                 led_d, decoupled_d, fallback_d;

  logic [NUM_SRC-1:0]   src_p0;
  logic [NUM_SRC-1:0]   stale_q;
  logic [FB_DIV:0]      fb_cnt_q;
  logic                 fb;

  logic                 sel_in_range, sel_src, sel_stale;
  logic                 run_fallback, run_led;

  // Stage p0: single capture of the RP outputs, which may glitch while reconfiguring
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      src_p0 <= '0;
    end else begin
      src_p0 <= src_i;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      fb_cnt_q <= '0;
    end else begin
      fb_cnt_q <= fb_cnt_q + 1'b1;
    end
  end

  assign fb = fb_cnt_q[FB_DIV];

`ifdef DFX_LED_MUX_STALE_EN
  localparam int            WD_W      = $clog2(STALE_CYC + 1);
  localparam logic [WD_W-1:0] STALE_MAX = WD_W'(STALE_CYC);

  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
    return (v >= STALE_MAX) ? STALE_MAX : v + 1'b1;
  endfunction

  logic [NUM_SRC-1:0] src_p1;
  logic [WD_W-1:0]    wd_q [NUM_SRC];
  logic [WD_W-1:0]    wd_d [NUM_SRC];

  // Counters are held at zero for as long as the RP is isolated
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      wd_d[i] = wd_sat_inc(wd_q[i]);
      if (decouple_i || (src_p0[i] != src_p1[i])) begin
        wd_d[i] = '0;
      end
    end
  end

  // Stage p1: edge history and watchdog state
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      src_p1  <= '0;
      stale_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wd_q[i] <= '0;
      end
    end else begin
      src_p1 <= src_p0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wd_q[i]    <= wd_d[i];
        stale_q[i] <= (wd_d[i] == STALE_MAX);
      end
    end
  end
`else
  assign stale_q = '0;
`endif

  assign stale_o = stale_q;

  always_comb begin
    sel_in_range = 1'b0;
    sel_src      = SAFE_VAL;
    sel_stale    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_sel_o == SEL_W'(i)) begin
        sel_in_range = 1'b1;
        sel_src      = src_p0[i];
        sel_stale    = stale_q[i];
      end
    end
  end

  assign run_fallback = !sel_in_range || sel_stale;
  assign run_led      = run_fallback ? fb : sel_src;

  always_comb begin
    state_d      = state_q;
    pend_sel_d   = pend_sel_q;
    blank_cnt_d  = blank_cnt_q;
    active_sel_d = active_sel_o;
    led_d        = SAFE_VAL;
    fallback_d   = 1'b0;
    decoupled_d  = 1'b0;
    if (decouple_i) begin
      state_d     = ST_DECOUPLED;
      decoupled_d = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          led_d      = run_led;
          fallback_d = run_fallback;
          if (sel_i != active_sel_o) begin
            state_d     = ST_BLANK;
            pend_sel_d  = sel_i;
            blank_cnt_d = BLANK_LOAD;
          end
        end
        ST_BLANK: begin
          // A new request while blanking restarts the full interval
          if (sel_i != pend_sel_q) begin
            pend_sel_d  = sel_i;
            blank_cnt_d = BLANK_LOAD;
          end else if (blank_cnt_q == '0) begin
            active_sel_d = pend_sel_q;
            state_d      = ST_RUN;
          end else begin
            blank_cnt_d = blank_cnt_q - 1'b1;
          end
        end
        ST_DECOUPLED: begin
          state_d     = ST_BLANK;
          pend_sel_d  = sel_i;
          blank_cnt_d = BLANK_LOAD;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Stage p2: control state and registered board outputs
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pend_sel_q   <= '0;
      blank_cnt_q  <= '0;
      active_sel_o <= '0;
      led_o        <= SAFE_VAL;
      decoupled_o  <= 1'b0;
      fallback_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_sel_q   <= pend_sel_d;
      blank_cnt_q  <= blank_cnt_d;
      active_sel_o <= active_sel_d;
      led_o        <= led_d;
      decoupled_o  <= decoupled_d;
      fallback_o   <= fallback_d;
    end
  end

endmodule

// File: tb/tb_dfx_led_mux.sv
// Self-checking bench for dfx_led_mux: scoreboard of predicted outputs plus directed spot checks.
`timescale 1ns/1ps
module tb_dfx_led_mux;

  localparam int   NSRC  = 3;
  localparam int   BLANK = 16;
  localparam int   STALE = 64;
  localparam int   FBD   = 3;
  localparam logic SAFE  = 1'b0;
`ifdef DFX_LED_MUX_STALE_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif
  localparam int S_RUN = 0, S_BLANK = 1, S_DEC = 2;

  logic       clk100 = 1'b0;
  logic       rst;
  logic [2:0] src_i;
  logic [1:0] sel_i;
  logic       decouple_i;
  logic       led_o, decoupled_o, fallback_o;
  logic [1:0] active_sel_o;
  logic [2:0] stale_o;

  dfx_led_mux #(
    .NUM_SRC(NSRC), .SEL_W(2), .BLANK_CYC(BLANK), .STALE_CYC(STALE),
    .FB_DIV(FBD), .SAFE_VAL(SAFE)
  ) dut (
    .clk100(clk100), .rst(rst), .src_i(src_i), .sel_i(sel_i),
    .decouple_i(decouple_i), .led_o(led_o), .decoupled_o(decoupled_o),
    .active_sel_o(active_sel_o), .stale_o(stale_o), .fallback_o(fallback_o)
  );

  always #5 clk100 = ~clk100;

  typedef struct packed {
    logic       led;
    logic       dec;
    logic [1:0] act;
    logic [2:0] stale;
    logic       fb;
  } exp_t;

  exp_t  sb_q[$];
  int    n_vec, n_bad;
  string tag;

  // Bench-side behavioural model, stepped once per clock edge
  logic [2:0] m_srcq, m_srcprev, m_stale;
  logic [1:0] m_pend, m_act;
  int         m_wd[3];
  int         m_st, m_left, m_fbc;

  task automatic model_reset();
    m_srcq = '0; m_srcprev = '0; m_stale = '0;
    m_pend = '0; m_act = '0;
    m_st = S_RUN; m_left = 0; m_fbc = 0;
    for (int i = 0; i < NSRC; i++) m_wd[i] = 0;
  endtask

  task automatic predict(input logic [2:0] src, input logic [1:0] sel, input logic dec);
    exp_t e;
    logic fbbit, use_fb, drive;
    logic [2:0] edges;
    fbbit  = m_fbc[FBD];
    use_fb = 1'b1;
    drive  = fbbit;
    if (int'(m_act) < NSRC) begin
      use_fb = STALE_EN && m_stale[m_act];
      drive  = use_fb ? fbbit : m_srcq[m_act];
    end
    e.led = SAFE;
    e.fb  = 1'b0;
    e.dec = dec;
    if (dec) begin
      m_st = S_DEC;
    end else if (m_st == S_RUN) begin
      e.led = drive;
      e.fb  = use_fb;
      if (sel != m_act) begin
        m_st = S_BLANK; m_pend = sel; m_left = BLANK;
      end
    end else if (m_st == S_BLANK) begin
      if (sel != m_pend) begin
        m_pend = sel; m_left = BLANK;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_st = S_RUN; m_act = m_pend;
        end
      end
    end else begin
      m_st = S_BLANK; m_pend = sel; m_left = BLANK;
    end
    e.act = m_act;
    edges = m_srcq ^ m_srcprev;
    for (int i = 0; i < NSRC; i++) begin
      if (dec || edges[i]) m_wd[i] = 0;
      else if (m_wd[i] < STALE) m_wd[i]++;
      m_stale[i] = STALE_EN && (m_wd[i] == STALE);
    end
    e.stale   = m_stale;
    m_srcprev = m_srcq;
    m_srcq    = src;
    m_fbc     = (m_fbc + 1) % (1 << (FBD + 1));
    sb_q.push_back(e);
  endtask

  // Drive one cycle at the falling edge, compare after the next rising edge
  task automatic cyc(input logic [2:0] src, input logic [1:0] sel, input logic dec);
    exp_t e, o;
    src_i = src; sel_i = sel; decouple_i = dec;
    predict(src, sel, dec);
    @(posedge clk100);
    @(negedge clk100);
    e = sb_q.pop_front();
    o = {led_o, decoupled_o, active_sel_o, stale_o, fallback_o};
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed led=%b dec=%b act=%0d stale=%b fb=%b required led=%b dec=%b act=%0d stale=%b fb=%b",
             tag, $time, o.led, o.dec, o.act, o.stale, o.fb, e.led, e.dec, e.act, e.stale, e.fb);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed=%0d required=%0d", name, $time, obs, req);
    end
  endtask

  task automatic check_reset(input string name);
    exp_t o;
    o = {led_o, decoupled_o, active_sel_o, stale_o, fallback_o};
    n_vec++;
    assert (o === {SAFE, 1'b0, 2'd0, 3'd0, 1'b0}) else begin
      n_bad++;
      $error("FAIL %s t=%0t observed=%b required=%b", name, $time, o, {SAFE, 1'b0, 2'd0, 3'd0, 1'b0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion by 200000 ns, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   zeros, flips;
    logic prev;
    n_vec = 0; n_bad = 0; tag = "reset";
    rst = 1'b1; src_i = 3'b111; sel_i = 2'd0; decouple_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk100);
    check_reset("rst_early");
    repeat (3) @(negedge clk100);
    check_reset("rst_late");
    rst = 1'b0;

    tag = "p1_follow";
    repeat (4) cyc(3'b111, 2'd0, 1'b0);
    cyc(3'b110, 2'd0, 1'b0);
    check_val("p1_lag1", 32'(led_o), 32'd1);
    cyc(3'b110, 2'd0, 1'b0);
    check_val("p1_lag2", 32'(led_o), 32'd0);
    for (int t = 0; t < 8; t++) cyc(3'(t * 5 + 3), 2'd0, 1'b0);

    tag = "p2_blank";
    repeat (2) cyc(3'b101, 2'd0, 1'b0);
    cyc(3'b101, 2'd2, 1'b0);
    check_val("p2_no_early_blank", 32'(led_o), 32'd1);
    zeros = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(3'b101, 2'd2, 1'b0);
      if (led_o === SAFE) zeros++;
    end
    check_val("p2_blank_len", 32'(zeros), 32'(BLANK));
    check_val("p2_active", 32'(active_sel_o), 32'd2);
    cyc(3'b001, 2'd2, 1'b0);
    check_val("p2_src2_lag1", 32'(led_o), 32'd1);
    cyc(3'b001, 2'd2, 1'b0);
    check_val("p2_src2_lag2", 32'(led_o), 32'd0);

    tag = "p3_restart";
    repeat (18) cyc(3'b111, 2'd0, 1'b0);
    cyc(3'b000, 2'd0, 1'b0);
    repeat (3) cyc(3'b111, 2'd0, 1'b0);
    repeat (9) cyc(3'b111, 2'd2, 1'b0);
    cyc(3'b111, 2'd1, 1'b0);
    zeros = 0;
    for (int t = 0; t < 21; t++) begin
      cyc(3'b111, 2'd1, 1'b0);
      if (led_o === SAFE) zeros++;
    end
    check_val("p3_blank_after_restart", 32'(zeros), 32'(BLANK));
    check_val("p3_active", 32'(active_sel_o), 32'd1);

    tag = "p4_decouple";
    for (int t = 0; t < 6; t++) cyc(t[0] ? 3'b111 : 3'b000, 2'd1, 1'b0);
    for (int t = 0; t < 10; t++) begin
      cyc(t[0] ? 3'b000 : 3'b111, 2'd0, 1'b1);
      check_val("p4_isolated", 32'({decoupled_o, led_o, stale_o}), 32'({1'b1, SAFE, 3'b000}));
    end
    check_val("p4_active_held", 32'(active_sel_o), 32'd1);
    cyc(3'b111, 2'd0, 1'b0);
    check_val("p4_exit_ack", 32'({decoupled_o, led_o}), 32'({1'b0, SAFE}));
    zeros = 0;
    for (int t = 0; t < 19; t++) begin
      cyc(3'b111, 2'd0, 1'b0);
      if (led_o === SAFE) zeros++;
    end
    check_val("p4_exit_blank", 32'(zeros), 32'(BLANK));
    check_val("p4_pend_sel", 32'(active_sel_o), 32'd0);

    tag = "p5_stale";
    for (int t = 0; t < 20; t++) cyc(3'(t * 5 + 3), 2'd1, 1'b0);
    for (int t = 0; t < 70; t++) cyc(t[0] ? 3'b111 : 3'b010, 2'd1, 1'b0);
    check_val("p5_stale_flag", 32'(stale_o), 32'({1'b0, STALE_EN, 1'b0}));
    check_val("p5_fallback", 32'(fallback_o), 32'(STALE_EN));
    flips = 0;
    prev  = led_o;
    for (int t = 0; t < 32; t++) begin
      cyc(t[0] ? 3'b111 : 3'b010, 2'd1, 1'b0);
      if (led_o !== prev) flips++;
      prev = led_o;
    end
    check_val("p5_blink_flips", 32'(flips), STALE_EN ? 32'd4 : 32'd0);
    repeat (3) cyc(3'b000, 2'd1, 1'b0);
    check_val("p5_recover", 32'({stale_o, fallback_o, led_o}), 32'({3'b000, 1'b0, 1'b0}));
    repeat (2) cyc(3'b010, 2'd1, 1'b0);
    check_val("p5_follow", 32'(led_o), 32'd1);

    tag = "p6_oor";
    for (int t = 0; t < 20; t++) cyc(3'(t * 5 + 3), 2'd3, 1'b0);
    check_val("p6_state", 32'({fallback_o, active_sel_o, stale_o}), 32'({1'b1, 2'd3, 3'b000}));
    flips = 0;
    prev  = led_o;
    for (int t = 0; t < 32; t++) begin
      cyc(3'(t * 3 + 1), 2'd3, 1'b0);
      if (led_o !== prev) flips++;
      prev = led_o;
    end
    check_val("p6_blink_flips", 32'(flips), 32'd4);

    tag = "p7_rst_mid";
    for (int t = 0; t < 5; t++) cyc(3'(t * 3 + 1), 2'd0, 1'b0);
    check_val("p7_mid_blank", 32'({active_sel_o, led_o}), 32'({2'd3, SAFE}));
    rst = 1'b1;
    #1;
    check_reset("rst_async");
    @(negedge clk100);
    check_reset("rst_mid_held");
    rst = 1'b0;
    model_reset();
    repeat (4) cyc(3'b111, 2'd0, 1'b0);
    check_val("p7_after_reset", 32'({active_sel_o, led_o, decoupled_o}), 32'({2'd0, 1'b1, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
